// File: rtl/handshake_trace_top.sv
// TCP passive-open handshake engine: answers SYNs with SYN-ACKs and
// tracks each flow in a small table until its final ACK establishes it.
module handshake_trace_top #(
  parameter int          FLOW_CNT                     = 8,
  parameter int          IP_ADDR_WIDTH                = 32,
  parameter int          TCP_HEADER_WIDTH             = 160,
  parameter int          PAYLOAD_BUF_ENTRY_ADDR_WIDTH = 16,
  parameter int          PAYLOAD_BUF_ENTRY_LEN_WIDTH  = 16,
  parameter logic [31:0] LOCAL_ISN                    = 32'h0000_1000,
  parameter logic [15:0] RX_WINDOW                    = 16'hFFFF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    parser_tcp_rx_hdr_val,
  output logic                                    tcp_parser_rx_rdy,
  input  logic [IP_ADDR_WIDTH-1:0]                parser_tcp_rx_src_ip,
  input  logic [IP_ADDR_WIDTH-1:0]                parser_tcp_rx_dst_ip,
  input  logic [TCP_HEADER_WIDTH-1:0]             parser_tcp_rx_tcp_hdr,
  input  logic                                    parser_tcp_rx_payload_val,
  input  logic [PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0] parser_tcp_rx_payload_addr,
  input  logic [PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]  parser_tcp_rx_payload_len,
  output logic                                    tcp_parser_tx_val,
  input  logic                                    parser_tcp_tx_rdy,
  output logic [IP_ADDR_WIDTH-1:0]                tcp_parser_tx_src_ip,
  output logic [IP_ADDR_WIDTH-1:0]                tcp_parser_tx_dst_ip,
  output logic [TCP_HEADER_WIDTH-1:0]             tcp_parser_tx_tcp_hdr,
  output logic [PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0] tcp_parser_tx_payload_addr,
  output logic [PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]  tcp_parser_tx_payload_len
);

  localparam int AW = IP_ADDR_WIDTH;
  localparam int IW = (FLOW_CNT > 1) ? $clog2(FLOW_CNT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_SEND} state_t;

  state_t r_state, w_next;
  logic   r_rdy;

  logic [AW-1:0]               r_sip, r_dip;
  logic [TCP_HEADER_WIDTH-1:0] r_hdr;

  logic [FLOW_CNT-1:0] r_vld, r_est;
  logic [AW-1:0]       r_rip   [FLOW_CNT];
  logic [AW-1:0]       r_lip   [FLOW_CNT];
  logic [15:0]         r_rport [FLOW_CNT];
  logic [15:0]         r_lport [FLOW_CNT];
  logic [31:0]         r_isn   [FLOW_CNT];

  logic [AW-1:0]               r_tx_sip, r_tx_dip;
  logic [TCP_HEADER_WIDTH-1:0] r_tx_hdr;

  logic        w_acc;
  logic [15:0] w_sport, w_dport;
  logic [31:0] w_seq, w_ack;
  logic        w_syn, w_ackf, w_rstf;
  logic        w_any, w_has_free;
  logic [IW-1:0] w_hidx, w_fidx;
  logic        w_hit_est;
  logic [31:0] w_hit_isn;
  logic        w_do_free, w_new_syn, w_do_alloc;
  logic        w_do_resend, w_do_est, w_send;
  logic [TCP_HEADER_WIDTH-1:0] w_reply;
  logic        w_unused;

  assign w_acc   = parser_tcp_rx_hdr_val & r_rdy;
  assign w_sport = r_hdr[159:144];
  assign w_dport = r_hdr[143:128];
  assign w_seq   = r_hdr[127:96];
  assign w_ack   = r_hdr[95:64];
  assign w_syn   = r_hdr[49];
  assign w_rstf  = r_hdr[50];
  assign w_ackf  = r_hdr[52];

  // Descending scans so the lowest matching/free index wins.
  always_comb begin
    w_any      = 1'b0;
    w_hidx     = '0;
    w_has_free = 1'b0;
    w_fidx     = '0;
    for (int i = FLOW_CNT - 1; i >= 0; i--) begin
      if (r_vld[i] && r_rip[i] == r_sip && r_lip[i] == r_dip &&
          r_rport[i] == w_sport && r_lport[i] == w_dport) begin
        w_any  = 1'b1;
        w_hidx = IW'(i);
      end
      if (!r_vld[i]) begin
        w_has_free = 1'b1;
        w_fidx     = IW'(i);
      end
    end
  end

  assign w_hit_est   = r_est[w_hidx];
  assign w_hit_isn   = r_isn[w_hidx];
  assign w_do_free   = w_rstf & w_any;
  assign w_new_syn   = w_syn & ~w_ackf & ~w_do_free;
  assign w_do_alloc  = w_new_syn & ~w_any & w_has_free;
  assign w_do_resend = w_new_syn & w_any & ~w_hit_est;
  assign w_do_est    = ~w_do_free & w_ackf & ~w_syn & w_any & ~w_hit_est &
                       (w_ack == LOCAL_ISN + 32'd1) &
                       (w_seq == w_hit_isn + 32'd1);
  assign w_send      = w_do_alloc | w_do_resend;

  assign w_reply = {w_dport, w_sport, LOCAL_ISN, w_seq + 32'd1,
                    4'd5, 3'd0, 9'h012, RX_WINDOW, 16'd0, 16'd0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= (w_next == S_IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_acc) w_next = S_LOOKUP;
      S_LOOKUP: w_next = w_send ? S_SEND : S_IDLE;
      S_SEND:   if (parser_tcp_tx_rdy) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sip <= '0;
      r_dip <= '0;
      r_hdr <= '0;
    end else if (w_acc) begin
      r_sip <= parser_tcp_rx_src_ip;
      r_dip <= parser_tcp_rx_dst_ip;
      r_hdr <= parser_tcp_rx_tcp_hdr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_est <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_do_free) r_vld[w_hidx] <= 1'b0;
      if (w_do_est)  r_est[w_hidx] <= 1'b1;
      if (w_do_alloc) begin
        r_vld[w_fidx] <= 1'b1;
        r_est[w_fidx] <= 1'b0;
      end
    end
  end

  // Keys are qualified by r_vld, so they need no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_LOOKUP && w_do_alloc) begin
      r_rip[w_fidx]   <= r_sip;
      r_lip[w_fidx]   <= r_dip;
      r_rport[w_fidx] <= w_sport;
      r_lport[w_fidx] <= w_dport;
      r_isn[w_fidx]   <= w_seq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_sip <= '0;
      r_tx_dip <= '0;
      r_tx_hdr <= '0;
    end else if (r_state == S_LOOKUP && w_send) begin
      r_tx_sip <= r_dip;
      r_tx_dip <= r_sip;
      r_tx_hdr <= w_reply;
    end
  end

  assign tcp_parser_rx_rdy          = r_rdy;
  assign tcp_parser_tx_val          = (r_state == S_SEND);
  assign tcp_parser_tx_src_ip       = r_tx_sip;
  assign tcp_parser_tx_dst_ip       = r_tx_dip;
  assign tcp_parser_tx_tcp_hdr      = r_tx_hdr;
  assign tcp_parser_tx_payload_addr = '0;
  assign tcp_parser_tx_payload_len  = '0;

  assign w_unused = ^{parser_tcp_rx_payload_val, parser_tcp_rx_payload_addr,
                      parser_tcp_rx_payload_len, r_hdr[63:53], r_hdr[51],
                      r_hdr[48:0]};

endmodule

// File: tb/tb_handshake_trace_top.sv
// Randomized bench for handshake_trace_top against a flow-list model
// of the TCP passive-open rules.
module tb_handshake_trace_top;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         val = 1'b0;
  logic         rx_rdy;
  logic [31:0]  src_ip = '0, dst_ip = '0;
  logic [159:0] hdr = '0;
  logic         tx_val;
  logic         tx_rdy = 1'b1;
  logic [31:0]  tx_sip, tx_dip;
  logic [159:0] tx_hdr;
  logic [15:0]  tx_addr, tx_len;

  int n_tests = 0;
  int n_fail  = 0;
  logic [159:0] seen_hdr;

  always #5 clk = ~clk;

  handshake_trace_top dut (
    .clk                        (clk),
    .rst                        (rst),
    .parser_tcp_rx_hdr_val      (val),
    .tcp_parser_rx_rdy          (rx_rdy),
    .parser_tcp_rx_src_ip       (src_ip),
    .parser_tcp_rx_dst_ip       (dst_ip),
    .parser_tcp_rx_tcp_hdr      (hdr),
    .parser_tcp_rx_payload_val  (1'b0),
    .parser_tcp_rx_payload_addr (16'h0),
    .parser_tcp_rx_payload_len  (16'h0),
    .tcp_parser_tx_val          (tx_val),
    .parser_tcp_tx_rdy          (tx_rdy),
    .tcp_parser_tx_src_ip       (tx_sip),
    .tcp_parser_tx_dst_ip       (tx_dip),
    .tcp_parser_tx_tcp_hdr      (tx_hdr),
    .tcp_parser_tx_payload_addr (tx_addr),
    .tcp_parser_tx_payload_len  (tx_len)
  );

  typedef struct {
    bit          v;
    bit          est;
    logic [31:0] rip, lip, isn;
    logic [15:0] rp, lp;
  } flow_t;

  flow_t m [8];

  localparam logic [8:0] F_SYN = 9'h002;
  localparam logic [8:0] F_RST = 9'h004;
  localparam logic [8:0] F_ACK = 9'h010;

  task automatic chk(input string tag, input logic [159:0] got,
                     input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] mk(input logic [15:0] sp, dp,
                                      input logic [31:0] seq, ack,
                                      input logic [8:0] fl);
    return {sp, dp, seq, ack, 4'd5, 3'd0, fl, 16'h4000, 16'h0, 16'h0};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m[i].v   = 0;
      m[i].est = 0;
    end
  endtask

  task automatic model(input logic [31:0] sip, dip, input logic [159:0] h,
                       output bit snd, output logic [159:0] eh);
    logic [15:0] sp, dp;
    logic [31:0] seq, ack;
    bit syn, ak, rs;
    int idx, fr;
    sp  = h[159:144];
    dp  = h[143:128];
    seq = h[127:96];
    ack = h[95:64];
    syn = h[49];
    rs  = h[50];
    ak  = h[52];
    snd = 0;
    eh  = {dp, sp, 32'h1000, seq + 32'd1, 4'd5, 3'd0, 9'h012,
           16'hFFFF, 32'h0};
    idx = -1;
    fr  = -1;
    for (int i = 0; i < 8; i++) begin
      if (m[i].v && m[i].rip == sip && m[i].lip == dip &&
          m[i].rp == sp && m[i].lp == dp) idx = i;
      if (!m[i].v && fr < 0) fr = i;
    end
    if (rs && idx >= 0) begin
      m[idx].v = 0;
    end else if (syn && !ak && idx < 0) begin
      if (fr >= 0) begin
        m[fr] = '{v: 1, est: 0, rip: sip, lip: dip, isn: seq,
                  rp: sp, lp: dp};
        snd = 1;
      end
    end else if (syn && !ak && !m[idx].est) begin
      snd = 1;
    end else if (ak && !syn && idx >= 0 && !m[idx].est &&
                 ack == 32'h1001 && seq == m[idx].isn + 32'd1) begin
      m[idx].est = 1;
    end
  endtask

  task automatic xact(input logic [31:0] sip, dip,
                      input logic [15:0] sp, dp,
                      input logic [31:0] seq, ack,
                      input logic [8:0] fl, input int hold);
    logic [159:0] h, eh;
    bit snd;
    int w;
    h = mk(sp, dp, seq, ack, fl);
    model(sip, dip, h, snd, eh);
    w = 0;
    while (!rx_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!rx_rdy) chk("rdy_timeout", 0, 1);
    tx_rdy = (hold == 0);
    val    = 1'b1;
    src_ip = sip;
    dst_ip = dip;
    hdr    = h;
    @(negedge clk);
    val    = 1'b0;
    hdr    = ~h;
    src_ip = ~sip;
    chk("lookup_txval", tx_val, 0);
    chk("lookup_rdy", rx_rdy, 0);
    @(negedge clk);
    chk("txval", tx_val, snd);
    if (snd) begin
      seen_hdr = tx_hdr;
      chk("tx_src", tx_sip, dip);
      chk("tx_dst", tx_dip, sip);
      chk("tx_hdr", tx_hdr, eh);
      chk("tx_addr", tx_addr, 0);
      chk("tx_len", tx_len, 0);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold_val", tx_val, 1);
        chk("hold_hdr", tx_hdr, eh);
        chk("hold_src", tx_sip, dip);
        chk("hold_rdy", rx_rdy, 0);
      end
      tx_rdy = 1'b1;
      @(negedge clk);
    end
    tx_rdy = 1'b1;
    chk("done_txval", tx_val, 0);
    chk("done_rdy", rx_rdy, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    val = 1'b0;
    @(negedge clk);
    chk("rst_rdy", rx_rdy, 0);
    chk("rst_txval", tx_val, 0);
    chk("rst_hdr", tx_hdr, 0);
    chk("rst_sip", tx_sip, 0);
    model_clear();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_rdy", rx_rdy, 1);
  endtask

  localparam logic [31:0] IP1 = 32'h0A00_0001;
  localparam logic [31:0] IP2 = 32'h0A00_0002;
  localparam logic [31:0] IP3 = 32'h0A00_0003;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  fls [6];
    logic [31:0] seqs [5];
    fls  = '{F_SYN, F_ACK, F_RST, F_SYN | F_ACK, 9'h000, F_RST | F_SYN};
    seqs = '{32'h100, 32'h101, 32'h200, 32'h201, 32'hFFFF_FFFF};
    model_clear();
    do_reset();

    xact(IP1, IP2, 16'd1234, 16'd80, 32'h100, 32'h0, F_SYN, 0);
    chk("synack_literal", seen_hdr,
        {16'd80, 16'd1234, 32'h1000, 32'h101, 4'd5, 3'd0, 9'h012,
         16'hFFFF, 32'h0});
    xact(IP1, IP2, 16'd1234, 16'd80, 32'h101, 32'h1001, F_ACK, 0);
    xact(IP1, IP2, 16'd1234, 16'd80, 32'h100, 32'h0, F_SYN, 0);

    xact(IP1, IP2, 16'd1235, 16'd80, 32'h200, 32'h0, F_SYN, 0);
    xact(IP1, IP2, 16'd1235, 16'd80, 32'h200, 32'h0, F_SYN, 5);
    xact(IP1, IP2, 16'd1235, 16'd80, 32'h201, 32'h1005, F_ACK, 0);
    xact(IP1, IP2, 16'd1235, 16'd80, 32'h201, 32'h1001, F_ACK, 0);
    xact(IP1, IP2, 16'd1235, 16'd80, 32'h200, 32'h0, F_SYN, 0);

    do_reset();
    for (int i = 0; i < 9; i++)
      xact(IP1, IP2, 16'(2000 + i), 16'd80, 32'h300 + i, 32'h0, F_SYN, 0);
    xact(IP1, IP2, 16'd2000, 16'd80, 32'h0, 32'h0, F_RST, 0);
    xact(IP1, IP2, 16'd3000, 16'd80, 32'h400, 32'h0, F_SYN, 1);
    xact(IP1, IP2, 16'd3001, 16'd80, 32'h500, 32'h0, F_SYN, 0);
    xact(IP1, IP2, 16'd3000, 16'd80, 32'h401, 32'h1001, F_ACK, 0);

    do_reset();
    xact(IP3, IP2, 16'd4000, 16'd443, 32'hFFFF_FFFF, 32'h0, F_SYN, 0);
    chk("ack_wrap", seen_hdr[95:64], 32'h0);

    tx_rdy = 1'b0;
    val    = 1'b1;
    src_ip = IP1;
    dst_ip = IP2;
    hdr    = mk(16'd5000, 16'd80, 32'h10, 32'h0, F_SYN);
    @(negedge clk);
    val = 1'b0;
    @(negedge clk);
    chk("pre_rst_val", tx_val, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_val", tx_val, 0);
    chk("mid_rst_rdy", rx_rdy, 0);
    chk("mid_rst_hdr", tx_hdr, 0);
    model_clear();
    @(negedge clk);
    rst    = 1'b0;
    tx_rdy = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", rx_rdy, 1);
    xact(IP1, IP2, 16'd5000, 16'd80, 32'h10, 32'h0, F_SYN, 0);
    xact(IP3, IP2, 16'd4000, 16'd443, 32'h0, 32'h1001, F_ACK, 0);

    for (int n = 0; n < 300; n++) begin
      xact(($urandom % 2) ? IP1 : IP3, IP2,
           16'(1000 + $urandom % 10), 16'd80,
           seqs[$urandom % 5],
           ($urandom % 4 == 0) ? 32'h1005 : 32'h1001,
           fls[$urandom % 6], $urandom % 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
